// File: rtl/scr1_tcm_sp_arbiter.sv
// scr1_tcm_sp_arbiter: arbitrates imem/dmem requests onto one single-port TCM SRAM (1-cycle read latency).
// Define SCR1_TCM_ARB_RR_EN for round-robin tie-break instead of dmem priority with an imem starvation guard.
`ifndef SCR1_IMEM_AWIDTH
`define SCR1_IMEM_AWIDTH 32
`endif
`ifndef SCR1_IMEM_DWIDTH
`define SCR1_IMEM_DWIDTH 32
`endif
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_memif_pkg;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_tcm_sp_arbiter
    import scr1_memif_pkg::*;
#(
`ifndef SCR1_TCM_ARB_RR_EN
    parameter int unsigned STARVE_LIMIT = 4,
`endif
    parameter logic [`SCR1_IMEM_AWIDTH-1:0] SCR1_TCM_SIZE = `SCR1_IMEM_AWIDTH'h00010000
)(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                imem_req,
    input  type_scr1_mem_cmd_e                  imem_cmd,
    input  logic [`SCR1_IMEM_AWIDTH-1:0]        imem_addr,
    output logic                                imem_req_ack,
    output logic [`SCR1_IMEM_DWIDTH-1:0]        imem_rdata,
    output type_scr1_mem_resp_e                 imem_resp,
    input  logic                                dmem_req,
    input  type_scr1_mem_cmd_e                  dmem_cmd,
    input  type_scr1_mem_width_e                dmem_width,
    input  logic [`SCR1_DMEM_AWIDTH-1:0]        dmem_addr,
    input  logic [`SCR1_DMEM_DWIDTH-1:0]        dmem_wdata,
    output logic                                dmem_req_ack,
    output logic [`SCR1_DMEM_DWIDTH-1:0]        dmem_rdata,
    output type_scr1_mem_resp_e                 dmem_resp,
    output logic                                sram_rena,
    output logic                                sram_wena,
    output logic [3:0]                          sram_weba,
    output logic [$clog2(SCR1_TCM_SIZE)-3:0]    sram_addra,
    output logic [31:0]                         sram_dataa,
    input  logic [31:0]                         sram_qa
);
    localparam int unsigned TCM_AW = $clog2(SCR1_TCM_SIZE);

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_IMEM = 2'b01,
        GNT_DMEM = 2'b10
    } type_gnt_e;

    type_gnt_e   r_resp_sel;
    type_gnt_e   w_resp_sel_next;
    logic        w_imem_gnt;
    logic        w_dmem_gnt;
    logic        w_dmem_wr;
    logic [1:0]  r_shift;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_unused;

`ifdef SCR1_TCM_ARB_RR_EN
    logic        r_last_gnt_dmem;
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0]  r_starve_cnt;
`endif

    // Grants are forced low while in reset so no SRAM access or ack escapes.
    always_comb begin
        w_imem_gnt = 1'b0;
        w_dmem_gnt = 1'b0;
        if (rst_n) begin
            if (imem_req && dmem_req) begin
`ifdef SCR1_TCM_ARB_RR_EN
                w_imem_gnt = r_last_gnt_dmem;
`else
                w_imem_gnt = (r_starve_cnt == LIMIT);
`endif
                w_dmem_gnt = ~w_imem_gnt;
            end else begin
                w_imem_gnt = imem_req;
                w_dmem_gnt = dmem_req;
            end
        end
    end

    always_comb begin
        w_resp_sel_next = GNT_NONE;
        if (w_imem_gnt) begin
            w_resp_sel_next = GNT_IMEM;
        end else if (w_dmem_gnt) begin
            w_resp_sel_next = GNT_DMEM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_sel <= GNT_NONE;
        end else begin
            r_resp_sel <= w_resp_sel_next;
        end
    end

`ifdef SCR1_TCM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt_dmem <= 1'b0;
        end else if (w_imem_gnt) begin
            r_last_gnt_dmem <= 1'b0;
        end else if (w_dmem_gnt) begin
            r_last_gnt_dmem <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!imem_req || w_imem_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != 4'hF) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`endif

    assign w_dmem_wr = w_dmem_gnt && (dmem_cmd == SCR1_MEM_CMD_WR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else if (w_dmem_gnt && !w_dmem_wr) begin
            r_shift <= dmem_addr[1:0];
        end
    end

    always_comb begin
        w_be    = '0;
        w_wdata = dmem_wdata;
        case (dmem_width)
            SCR1_MEM_WIDTH_BYTE: begin
                w_be    = 4'b0001 << dmem_addr[1:0];
                w_wdata = {4{dmem_wdata[7:0]}};
            end
            SCR1_MEM_WIDTH_HWORD: begin
                w_be    = 4'b0011 << {dmem_addr[1], 1'b0};
                w_wdata = {2{dmem_wdata[15:0]}};
            end
            SCR1_MEM_WIDTH_WORD: begin
                w_be    = 4'b1111;
                w_wdata = dmem_wdata;
            end
            default: begin
                w_be    = '0;
                w_wdata = dmem_wdata;
            end
        endcase
    end

    // High address bits beyond the TCM size are dropped, so accesses wrap.
    assign sram_addra = w_imem_gnt ? imem_addr[TCM_AW-1:2] : dmem_addr[TCM_AW-1:2];
    assign sram_rena  = w_imem_gnt || (w_dmem_gnt && !w_dmem_wr);
    assign sram_wena  = w_dmem_wr;
    assign sram_weba  = w_dmem_wr ? w_be : 4'b0000;
    assign sram_dataa = w_wdata;

    assign imem_req_ack = w_imem_gnt;
    assign dmem_req_ack = w_dmem_gnt;

    assign imem_resp  = (r_resp_sel == GNT_IMEM) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
    assign dmem_resp  = (r_resp_sel == GNT_DMEM) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
    assign imem_rdata = sram_qa;
    assign dmem_rdata = sram_qa >> {r_shift, 3'b000};

    assign w_unused = ^{imem_cmd, imem_addr[`SCR1_IMEM_AWIDTH-1:TCM_AW], imem_addr[1:0],
                        dmem_addr[`SCR1_DMEM_AWIDTH-1:TCM_AW]};

endmodule

// File: doc/scr1_tcm_sp_arbiter.md
Name: scr1_tcm_sp_arbiter

Overview:
- Arbitrates the core's imem and dmem request ports onto one single-port TCM SRAM (scr1_sp_memory: rena/wena/weba/addra/dataa/qa, 1-cycle read latency).
- Sits between the core memory interfaces and the SRAM instance.
- Grants at most one access per cycle. Generates byte enables and replicated write data, and aligns dmem read data.
- Default policy is dmem-priority with an imem starvation guard.

Parameters:
- SCR1_TCM_SIZE, `SCR1_IMEM_AWIDTH'h00010000: TCM size in bytes, power of two; SRAM address = addr[$clog2(SCR1_TCM_SIZE)-1:2].
- STARVE_LIMIT, 4: consecutive cycles imem may be denied before a forced imem grant; range 1..15.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  in  1  instruction request
- imem_cmd  in  type_scr1_mem_cmd_e  always READ; a WR command is treated as a read
- imem_addr  in  `SCR1_IMEM_AWIDTH  instruction byte address
- imem_req_ack  out  1  request accepted this cycle
- imem_rdata  out  `SCR1_IMEM_DWIDTH  instruction word
- imem_resp  out  type_scr1_mem_resp_e  response
- dmem_req  in  1  data request
- dmem_cmd  in  type_scr1_mem_cmd_e  READ/WRITE
- dmem_width  in  type_scr1_mem_width_e  BYTE/HWORD/WORD
- dmem_addr  in  `SCR1_DMEM_AWIDTH  data byte address
- dmem_wdata  in  `SCR1_DMEM_DWIDTH  write data
- dmem_req_ack  out  1  request accepted this cycle
- dmem_rdata  out  `SCR1_DMEM_DWIDTH  read data, right-aligned
- dmem_resp  out  type_scr1_mem_resp_e  response
- sram_rena  out  1  SRAM read enable
- sram_wena  out  1  SRAM write enable
- sram_weba  out  4  SRAM byte enables
- sram_addra  out  $clog2(SCR1_TCM_SIZE)-2  SRAM word address
- sram_dataa  out  32  SRAM write data
- sram_qa  in  32  SRAM read data (valid cycle after rena)

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low.
  - Registered state goes to GNT_NONE.
  - Starvation counter = 0; shift register = 0.
  - imem_resp and dmem_resp = NOTRDY; both req_ack = 0 (combinational, gated while rst_n low).
  - No sram_rena or sram_wena during reset.
- Grant (combinational, cycle N):
  - Only imem_req: imem granted.
  - Only dmem_req: dmem granted.
  - Both: dmem granted unless starve_cnt == STARVE_LIMIT, in which case imem is granted.
  - Granted port: req_ack = 1; the other port: req_ack = 0.
  - sram_addra is muxed from the granted address.
  - sram_rena = 1 for an imem grant or a dmem read.
  - sram_wena = 1 only for a dmem WRITE grant; rena and wena are mutually exclusive.
- Starvation counter:
  - Increments (saturating) each cycle imem_req = 1 and imem is not granted.
  - Clears on any imem grant or when imem_req = 0.
- Response (registered, cycle N+1):
  - resp_sel register: GNT_NONE / GNT_IMEM / GNT_DMEM.
  - GNT_IMEM: imem_resp = RDY_OK, imem_rdata = sram_qa.
  - GNT_DMEM: dmem_resp = RDY_OK; writes also respond RDY_OK.
  - Non-selected port: resp = NOTRDY.
  - Back-to-back grants permitted every cycle; throughput 1 access/cycle.
- Write formatting:
  - BYTE: dataa = {4{wdata[7:0]}}, weba = 1 << addr[1:0].
  - HWORD: dataa = {2{wdata[15:0]}}, weba = 2'b11 << {addr[1],1'b0}.
  - WORD: dataa = wdata, weba = 4'b1111.
- Read alignment:
  - On a dmem read grant, register addr[1:0].
  - dmem_rdata = sram_qa >> (8*shift).
  - The shift register holds its value otherwise.
- Boundaries:
  - Address bits above the TCM size are ignored, so accesses wrap modulo the TCM size.
  - A request withdrawn before grant is dropped with no response.
  - Reset asserted mid-access: the pending response is discarded and no RDY_OK is issued after reset release.

Optional Feature:
- Macro SCR1_TCM_ARB_RR_EN.
- Defined: on simultaneous requests, grant the port not granted most recently, using a 1-bit last_gnt register (reset = imem, so dmem wins the first tie). The starvation counter and STARVE_LIMIT are unused and removed.
- Undefined: dmem-priority with the starvation guard, as above.

Test Plan:
- Reset, then imem_req = 1, addr 0x10, SRAM word 0x00000013 -> cycle 0 imem_req_ack = 1, sram_rena = 1, sram_addra = 4; cycle 1 imem_resp = RDY_OK, imem_rdata = 0x00000013.
- dmem BYTE write 0xA5 at addr 0x3 -> sram_wena = 1, sram_weba = 4'b1000, sram_dataa = 0xA5A5A5A5; next cycle dmem_resp = RDY_OK. Then a BYTE read at 0x3 -> dmem_rdata[7:0] = 0xA5.
- Both requests held continuously, STARVE_LIMIT = 4 -> dmem granted 4 cycles, imem granted on the 5th, pattern repeats. With SCR1_TCM_ARB_RR_EN defined, grants alternate dmem, imem, dmem, ...
- HWORD read at addr 0x2, SRAM word 0xBEEF1234 -> dmem_rdata[15:0] = 0xBEEF, dmem_resp = RDY_OK one cycle after ack.
- Alternate imem/dmem requests every cycle -> one grant and one RDY_OK every cycle, and the RDY_OK always lands on the port granted the previous cycle.
- rst_n dropped the cycle after a dmem read grant -> dmem_resp = NOTRDY immediately; after release both resp stay NOTRDY with no requests present.
